// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of SimpleALU: queues 16-bit host commands in a small
// FIFO and issues them one at a time, spacing issues by each opcode's ALU latency.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int MUL_CYC = 2,
  parameter int DIV_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd_in,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [15:0] alu_cmd,
  output logic        alu_go,
  output logic        busy,
  output logic        err,
  output logic [7:0]  issued_count,
  output logic        state_dbg
);
  localparam int AW   = $clog2(DEPTH);
  localparam int MAXL = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  // Legal opcodes are the contiguous range STO(1)..DIV(5); ADD=2, SUB=3 take one cycle.
  localparam logic [3:0] OP_STO = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_DIV = 4'd5;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ISSUED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [15:0]     mem_q [DEPTH];
  logic [15:0]     mem_d [DEPTH];
  logic [15:0]     alu_cmd_q, alu_cmd_d;
  logic            alu_go_q, alu_go_d;
  logic            err_q, err_d;
  logic [7:0]      issued_q, issued_d;

  logic            empty, full, push, pop, slot_free;
  logic [15:0]     head;

  function automatic logic op_legal(input logic [3:0] op);
    return (op >= OP_STO) && (op <= OP_DIV);
  endfunction

  function automatic logic [CW-1:0] op_lat_m1(input logic [3:0] op);
    case (op)
      OP_MUL:  op_lat_m1 = CW'(MUL_CYC - 1);
      OP_DIV:  op_lat_m1 = CW'(DIV_CYC - 1);
      default: op_lat_m1 = '0;
    endcase
  endfunction

  // Handshake: cmd_in is taken on a rising edge where cmd_valid && cmd_ready.
  // cmd_ready is !full from registered pointers only, so it never depends on cmd_valid
  // and stays low while full even if the head is popped in the same cycle.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push      = cmd_valid && !full;
  assign slot_free = (state_q == S_IDLE) || (cnt_q == '0);
  assign pop       = slot_free && !empty;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = cmd_in;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // An ISSUED slot with cnt==0 behaves exactly like IDLE, which keeps
  // single-cycle ops strobing every cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_cmd_d = alu_cmd_q;
    alu_go_d  = 1'b0;
    err_d     = 1'b0;
    issued_d  = issued_q;
    if (!slot_free) begin
      cnt_d = cnt_q - CW'(1);
    end else if (pop) begin
      if (op_legal(head[15:12])) begin
        alu_cmd_d = head;
        alu_go_d  = 1'b1;
        cnt_d     = op_lat_m1(head[15:12]);
        issued_d  = issued_q + 8'd1;
        state_d   = S_ISSUED;
      end else begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      alu_cmd_q <= 16'h0000;
      alu_go_q  <= 1'b0;
      err_q     <= 1'b0;
      issued_q  <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      alu_cmd_q <= alu_cmd_d;
      alu_go_q  <= alu_go_d;
      err_q     <= err_d;
      issued_q  <= issued_d;
      mem_q     <= mem_d;
    end
  end

  assign cmd_ready    = !full;
  assign alu_cmd      = alu_cmd_q;
  assign alu_go       = alu_go_q;
  assign err          = err_q;
  assign issued_count = issued_q;
  assign busy         = !empty || ((state_q == S_ISSUED) && (cnt_q != '0)) || alu_go_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: random and directed command streams checked
// against a slot-scheduling reference model of the issue rules.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  localparam int DEPTH   = 4;
  localparam int MUL_CYC = 2;
  localparam int DIV_CYC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cmd_in = 16'h0000;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready, alu_go, busy, err, state_dbg;
  logic [15:0] alu_cmd;
  logic [7:0]  issued_count;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .alu_cmd(alu_cmd), .alu_go(alu_go), .busy(busy),
    .err(err), .issued_count(issued_count), .state_dbg(state_dbg)
  );

  // Clock/reset block: posedge at 5,15,...; cyc numbers the rising edges.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: every accepted command gets an issue slot (the edge where
  // its alu_go/err is registered) = max(accept edge + 1, previous slot + previous L).
  int          model_free = 0;
  int          model_issued = 0;
  int          acc_q[$];
  int          pop_q[$];
  logic [15:0] exp_q[$];
  int          exp_slot_q[$];
  int          fl_end_q[$];
  int          exp_err_q[$];

  int          go_cyc_q[$];
  logic [15:0] go_cmd_q[$];
  int          err_cyc_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (alu_go === 1'b1) begin
        go_cyc_q.push_back(cyc);
        go_cmd_q.push_back(alu_cmd);
      end
      if (err === 1'b1) err_cyc_q.push_back(cyc);
    end
  end

  function automatic int op_lat(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd3: return 1;
      4'd4:             return MUL_CYC;
      4'd5:             return DIV_CYC;
      default:          return 0;
    endcase
  endfunction

  function automatic int model_occ(input int n);
    int o = 0;
    foreach (acc_q[i]) if (acc_q[i] <= n) o++;
    foreach (pop_q[i]) if (pop_q[i] <= n) o--;
    return o;
  endfunction

  function automatic logic model_busy(input int n);
    if (model_occ(n) > 0) return 1'b1;
    foreach (exp_slot_q[i]) if (n >= exp_slot_q[i] && n <= fl_end_q[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_accept(input logic [15:0] c, input int p);
    int slot;
    int l;
    slot = (p + 1 > model_free) ? p + 1 : model_free;
    l = op_lat(c[15:12]);
    acc_q.push_back(p);
    pop_q.push_back(slot);
    if (l > 0) begin
      exp_q.push_back(c);
      exp_slot_q.push_back(slot);
      fl_end_q.push_back(slot + ((l > 1) ? l - 2 : 0));
      model_free = slot + l;
      model_issued++;
    end else begin
      exp_err_q.push_back(slot);
      model_free = slot + 1;
    end
  endtask

  task automatic clear_logs();
    acc_q.delete(); pop_q.delete(); exp_q.delete(); exp_slot_q.delete();
    fl_end_q.delete(); exp_err_q.delete();
    go_cyc_q.delete(); go_cmd_q.delete(); err_cyc_q.delete();
  endtask

  // Driver: called at a negedge; returns at a negedge after acceptance.
  task automatic send(input logic [15:0] c);
    int guard = 0;
    cmd_in = c;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: cmd_ready=%b, required 1 within 200 cycles", cmd_ready);
    end else begin
      model_accept(c, cyc + 1);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int lim;
    lim = model_free + 3;
    while (cyc < lim) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++; if (alu_go !== 1'b0) begin n_fail++; $display("FAIL reset_alu_go: got %b want 0", alu_go); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (alu_cmd !== 16'h0000) begin n_fail++; $display("FAIL reset_alu_cmd: got %h want 0000", alu_cmd); end
    n_cmp++; if (issued_count !== 8'd0) begin n_fail++; $display("FAIL reset_issued: got %0d want 0", issued_count); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (state_dbg !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", state_dbg); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    model_free = 0;
    model_issued = 0;
  endtask

  task automatic test_basic();
    int lim;
    clear_logs();
    send(16'h1050); send(16'h1140); send(16'h4110); send(16'h2221);
    lim = model_free + 3;
    while (cyc < lim) begin
      n_cmp++;
      if (busy !== model_busy(cyc)) begin
        n_fail++; $display("FAIL basic_busy@%0d: got %b want %b", cyc, busy, model_busy(cyc));
      end
      @(negedge clk);
    end
    n_cmp++; if (go_cyc_q.size() != exp_slot_q.size()) begin n_fail++; $display("FAIL basic_go_count: got %0d want %0d", go_cyc_q.size(), exp_slot_q.size()); end
    foreach (exp_slot_q[i]) if (i < go_cyc_q.size()) begin
      n_cmp++;
      if (go_cyc_q[i] != exp_slot_q[i] || go_cmd_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL basic_go[%0d]: got cyc %0d cmd %h want cyc %0d cmd %h", i, go_cyc_q[i], go_cmd_q[i], exp_slot_q[i], exp_q[i]);
      end
    end
    n_cmp++; if (err_cyc_q.size() != 0) begin n_fail++; $display("FAIL basic_err_count: got %0d want 0", err_cyc_q.size()); end
    n_cmp++; if (issued_count !== 8'(model_issued)) begin n_fail++; $display("FAIL basic_issued: got %0d want %0d", issued_count, model_issued); end
  endtask

  task automatic test_div_fill();
    int i = 0;
    int guard = 0;
    logic exp_rdy;
    clear_logs();
    cmd_valid = 1'b1;
    while (i < 6 && guard < 300) begin
      cmd_in = {4'h5, 4'(i), 8'hA0 | 8'(i)};
      exp_rdy = (model_occ(cyc) < DEPTH);
      n_cmp++;
      if (cmd_ready !== exp_rdy) begin
        n_fail++; $display("FAIL div_ready@%0d: got %b want %b", cyc, cmd_ready, exp_rdy);
      end
      if (cmd_ready === 1'b1) begin
        model_accept(cmd_in, cyc + 1);
        i++;
      end
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b0;
    if (i < 6) begin n_cmp++; n_fail++; $display("FAIL div_push_timeout: pushed %0d want 6", i); end
    drain();
    n_cmp++; if (go_cyc_q.size() != exp_slot_q.size()) begin n_fail++; $display("FAIL div_go_count: got %0d want %0d", go_cyc_q.size(), exp_slot_q.size()); end
    foreach (exp_slot_q[k]) if (k < go_cyc_q.size()) begin
      n_cmp++;
      if (go_cyc_q[k] != exp_slot_q[k] || go_cmd_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL div_go[%0d]: got cyc %0d cmd %h want cyc %0d cmd %h", k, go_cyc_q[k], go_cmd_q[k], exp_slot_q[k], exp_q[k]);
      end
    end
    n_cmp++; if (issued_count !== 8'(model_issued)) begin n_fail++; $display("FAIL div_issued: got %0d want %0d", issued_count, model_issued); end
  endtask

  task automatic test_illegal();
    clear_logs();
    send(16'h2123); send(16'hF000); send(16'h3456);
    drain();
    n_cmp++; if (go_cyc_q.size() != 2) begin n_fail++; $display("FAIL illegal_go_count: got %0d want 2", go_cyc_q.size()); end
    foreach (exp_slot_q[i]) if (i < go_cyc_q.size()) begin
      n_cmp++;
      if (go_cyc_q[i] != exp_slot_q[i] || go_cmd_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL illegal_go[%0d]: got cyc %0d cmd %h want cyc %0d cmd %h", i, go_cyc_q[i], go_cmd_q[i], exp_slot_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (err_cyc_q.size() != 1 || err_cyc_q[0] != exp_err_q[0]) begin
      n_fail++; $display("FAIL illegal_err: got %0d pulses first@%0d want 1 pulse @%0d", err_cyc_q.size(), (err_cyc_q.size() > 0) ? err_cyc_q[0] : -1, exp_err_q[0]);
    end
    n_cmp++; if (issued_count !== 8'(model_issued)) begin n_fail++; $display("FAIL illegal_issued: got %0d want %0d", issued_count, model_issued); end
  endtask

  task automatic test_reset_mid_div();
    int target;
    clear_logs();
    send(16'h5011); send(16'h5022); send(16'h5033); send(16'h5044);
    target = exp_slot_q[0] + 3;
    while (cyc < target) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (alu_go !== 1'b0) begin n_fail++; $display("FAIL midrst_alu_go: got %b want 0", alu_go); end
    n_cmp++; if (alu_cmd !== 16'h0000) begin n_fail++; $display("FAIL midrst_alu_cmd: got %h want 0000", alu_cmd); end
    n_cmp++; if (issued_count !== 8'd0) begin n_fail++; $display("FAIL midrst_issued: got %0d want 0", issued_count); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    model_free = 0;
    model_issued = 0;
    repeat (20) @(negedge clk);
    n_cmp++; if (go_cyc_q.size() != 0 || err_cyc_q.size() != 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d go %0d err want 0 0", go_cyc_q.size(), err_cyc_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_after: got %b want 0", busy); end
    send(16'h1777);
    drain();
    n_cmp++;
    if (go_cyc_q.size() != 1 || go_cyc_q[0] != exp_slot_q[0] || go_cmd_q[0] !== 16'h1777) begin
      n_fail++; $display("FAIL midrst_first_issue: got %0d strobes want 1 @%0d cmd 1777", go_cyc_q.size(), exp_slot_q[0]);
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    for (int i = 0; i < 257; i++) send({4'h1, 12'(i)});
    drain();
    n_cmp++; if (go_cyc_q.size() != 257) begin n_fail++; $display("FAIL wrap_go_count: got %0d want 257", go_cyc_q.size()); end
    n_cmp++; if (issued_count !== 8'(model_issued)) begin n_fail++; $display("FAIL wrap_issued: got %0d want %0d", issued_count, 8'(model_issued)); end
  endtask

  task automatic test_push_pop_at_depth_m1();
    int target;
    clear_logs();
    send(16'h5100); send(16'h1200); send(16'h1300); send(16'h1400);
    target = pop_q[1];
    while (cyc < target - 1) @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready_before: got %b want 1", cmd_ready); end
    send(16'h1500);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready_after: got %b want 1", cmd_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pp_busy: got %b want 1", busy); end
    drain();
    n_cmp++; if (go_cyc_q.size() != 5) begin n_fail++; $display("FAIL pp_go_count: got %0d want 5", go_cyc_q.size()); end
    foreach (exp_slot_q[i]) if (i < go_cyc_q.size()) begin
      n_cmp++;
      if (go_cyc_q[i] != exp_slot_q[i] || go_cmd_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL pp_go[%0d]: got cyc %0d cmd %h want cyc %0d cmd %h", i, go_cyc_q[i], go_cmd_q[i], exp_slot_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [3:0] op;
    clear_logs();
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: op = 4'(r + 1);
        5:             op = 4'd0;
        6:             op = 4'($urandom_range(6, 15));
        default:       op = 4'($urandom_range(1, 3));
      endcase
      send({op, 12'($urandom)});
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    n_cmp++; if (go_cyc_q.size() != exp_slot_q.size()) begin n_fail++; $display("FAIL rand_go_count: got %0d want %0d", go_cyc_q.size(), exp_slot_q.size()); end
    foreach (exp_slot_q[i]) if (i < go_cyc_q.size()) begin
      n_cmp++;
      if (go_cyc_q[i] != exp_slot_q[i] || go_cmd_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_go[%0d]: got cyc %0d cmd %h want cyc %0d cmd %h", i, go_cyc_q[i], go_cmd_q[i], exp_slot_q[i], exp_q[i]);
      end
    end
    n_cmp++; if (err_cyc_q.size() != exp_err_q.size()) begin n_fail++; $display("FAIL rand_err_count: got %0d want %0d", err_cyc_q.size(), exp_err_q.size()); end
    foreach (exp_err_q[i]) if (i < err_cyc_q.size()) begin
      n_cmp++;
      if (err_cyc_q[i] != exp_err_q[i]) begin
        n_fail++; $display("FAIL rand_err[%0d]: got cyc %0d want cyc %0d", i, err_cyc_q[i], exp_err_q[i]);
      end
    end
    n_cmp++; if (issued_count !== 8'(model_issued)) begin n_fail++; $display("FAIL rand_issued: got %0d want %0d", issued_count, 8'(model_issued)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_fill();
    test_illegal();
    test_reset_mid_div();
    test_wrap();
    test_push_pop_at_depth_m1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command sequencer placed in front of `SimpleALU`. It buffers 16-bit ALU commands from a host in a small FIFO and issues them one at a time to the ALU, holding back the next command until the current operation's fixed latency has elapsed. Illegal opcodes are dropped and flagged. It keeps an issue counter for debug and bring-up.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `MUL_CYC`, 2: ALU cycles occupied by MUL; ≥1.
- `DIV_CYC`, 8: ALU cycles occupied by DIV; ≥1.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_in`  in  16  command word: [15:12] op, [11:8] dst, [7:4] a/imm, [3:0] b.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  FIFO can accept.
- `alu_cmd`  out  16  command presented to ALU, registered.
- `alu_go`  out  1  one-cycle strobe; `alu_cmd` is valid this cycle.
- `busy`  out  1  FIFO non-empty or an op is in flight.
- `err`  out  1  one-cycle pulse: an illegal opcode was dropped.
- `issued_count`  out  8  number of commands issued, wraps.

## Operation
- Opcodes: STO=1, ADD=2, SUB=3, MUL=4, DIV=5.
  - Latency L: STO/ADD/SUB = 1, MUL = `MUL_CYC`, DIV = `DIV_CYC`.
  - Opcodes 0 and 6–15 are illegal.
- FIFO push when `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`, combinational from registered FIFO state.
  - Entries are issued in arrival order.
- FSM states and transitions:
  - IDLE, when FIFO non-empty: pop head and decode.
    - Legal opcode: register `alu_cmd`, assert `alu_go` next cycle, load `cnt = L-1`, go to ISSUED.
    - Illegal opcode: discard, pulse `err`, stay IDLE; no `alu_go`, counter unchanged.
  - ISSUED, when `cnt != 0`: decrement `cnt`.
  - ISSUED, when `cnt == 0`: behave exactly as IDLE (pop/issue or drop); if FIFO empty, go to IDLE.
- `issued_count` increments on each `alu_go`; 255 wraps to 0.
- `alu_cmd` holds its last issued value between strobes.
- `busy = !empty || (state==ISSUED && cnt!=0) || alu_go`.
- Push and pop in the same cycle are both allowed; occupancy is unchanged.
  - When full, `cmd_ready` is low, even if a pop occurs that cycle.

## Timing
- Reset, async and applied immediately:
  - `alu_go=0`, `err=0`, `alu_cmd=16'h0000`, `issued_count=0`, `busy=0`, `cmd_ready=1`.
  - FIFO emptied, state IDLE, `cnt=0`.
  - Reset mid-operation discards queued and in-flight commands.
  - First push is accepted on the first edge after `rst` deasserts.
- Latency from a push into an empty idle block (edge E) to `alu_go` high: the cycle following edge E+1.
- Spacing of successive `alu_go` pulses with the queue continuously non-empty is exactly L of the earlier op.
  - Back-to-back STO/ADD/SUB strobe every cycle.
  - An illegal entry between two legal ones adds exactly 1 cycle.
- `err` is asserted in the same cycle slot where `alu_go` would have been.
- FIFO wrap: pointers are `log2(DEPTH)` bits plus a wrap bit; full/empty are computed from them.

## Test plan
- Reset then push STO(0,5,0), STO(1,4,0), MUL(1,1,0), ADD(2,2,1) on consecutive cycles.
  - `alu_go` pulses at cycles t, t+1, t+2, t+4 (`MUL_CYC`=2).
  - `alu_cmd` = 16'h1050, 16'h1140, 16'h4110, 16'h2221.
  - `issued_count` = 4; `busy` falls the cycle after the last strobe.
- Hold `cmd_valid` with 6 DIV commands (`DIV_CYC`=8).
  - `cmd_ready` drops after the FIFO fills to `DEPTH`.
  - Strobes are 8 cycles apart.
  - No command is lost or duplicated; order is preserved.
- Push ADD, opcode 4'hF, SUB.
  - `err` pulses once and `alu_go` is absent in that slot.
  - SUB issues 2 cycles after ADD; `issued_count` = 2.
- Assert `rst` asynchronously mid-DIV with 3 entries queued.
  - Outputs go to reset values immediately.
  - No further `alu_go` until new pushes arrive.
- Issue 257 STO commands.
  - `issued_count` reads 1 after the final strobe (wrap).
- Push while popping with the FIFO at `DEPTH-1`.
  - Occupancy is unchanged and `cmd_ready` stays high.
